// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Instruction fetch sequencer: IDLE -> FETCH (hold a read request at the
//   current PC until memory answers) -> WRITE (one-cycle IR write pulse).
//   The fetched word is captured in a register and the PC advances by PC_INC.
//
// Parameters
//   PC_RESET        PC value loaded on reset
//   PC_INC          PC increment per fetched instruction
//   TIMEOUT_CYCLES  FETCH cycles allowed before a fault (timeout build only)
//
// Ports
//   CLK, RST_N            clock, asynchronous active-low reset
//   input_FU_start        request to fetch the next instruction (IDLE only)
//   input_FU_pc_load      load PC from input_FU_pc_target (IDLE / WRITE)
//   input_FU_pc_target    branch / jump target
//   input_FU_mem_data     instruction memory read data
//   input_FU_mem_ready    read data valid (sampled in FETCH only)
//   Output_FU_mem_req     read request, high in FETCH
//   Output_FU_mem_addr    read address (current PC)
//   Output_FU_Instru      last successfully fetched instruction
//   Output_FU_IR_write    one-cycle instruction register write enable
//   Output_FU_PC          current PC
//   Output_FU_busy        high in FETCH or WRITE
//   Output_FU_fault       fetch timeout flag
//
// Build option
//   FETCH_TIMEOUT_EN  when defined, a FETCH that sees no ready for
//                     TIMEOUT_CYCLES cycles aborts to IDLE and sets the fault
//                     flag; otherwise FETCH waits forever and fault is 0.

module instr_fetch_unit #(
  parameter logic [15:0] PC_RESET       = 16'h0000,
  parameter logic [15:0] PC_INC         = 16'd2,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        input_FU_start,
  input  logic        input_FU_pc_load,
  input  logic [15:0] input_FU_pc_target,
  input  logic [15:0] input_FU_mem_data,
  input  logic        input_FU_mem_ready,
  output logic        Output_FU_mem_req,
  output logic [15:0] Output_FU_mem_addr,
  output logic [15:0] Output_FU_Instru,
  output logic        Output_FU_IR_write,
  output logic [15:0] Output_FU_PC,
  output logic        Output_FU_busy,
  output logic        Output_FU_fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;

`ifdef FETCH_TIMEOUT_EN
  // Counter holds the number of FETCH cycles already spent without ready,
  // so it only needs to reach TIMEOUT_CYCLES-1.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
`else
  // Timeout parameter is meaningless without the timer; tie it off here.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    fault_d = fault_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // Load and start on the same edge: the fetch uses the new target.
        if (input_FU_pc_load) pc_d = input_FU_pc_target;
        if (input_FU_start) begin
          state_d = S_FETCH;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
          fault_d = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        if (input_FU_mem_ready) begin
          instr_d = input_FU_mem_data;
          pc_d    = pc_q + PC_INC;
          state_d = S_WRITE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_WRITE: begin
        // A jump taken here replaces the increment applied on the fetch edge.
        if (input_FU_pc_load) pc_d = input_FU_pc_target;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RESET;
      instr_q <= '0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
`endif
    end
  end

  // Outputs decode the registered state only, so reset clears them at once.
  assign Output_FU_mem_req  = (state_q == S_FETCH);
  assign Output_FU_IR_write = (state_q == S_WRITE);
  assign Output_FU_busy     = (state_q != S_IDLE);
  assign Output_FU_mem_addr = pc_q;
  assign Output_FU_PC       = pc_q;
  assign Output_FU_Instru   = instr_q;
`ifdef FETCH_TIMEOUT_EN
  assign Output_FU_fault    = fault_q;
`else
  assign Output_FU_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        CLK;
  logic        RST_N;
  logic        input_FU_start;
  logic        input_FU_pc_load;
  logic [15:0] input_FU_pc_target;
  logic [15:0] input_FU_mem_data;
  logic        input_FU_mem_ready;
  logic        Output_FU_mem_req;
  logic [15:0] Output_FU_mem_addr;
  logic [15:0] Output_FU_Instru;
  logic        Output_FU_IR_write;
  logic [15:0] Output_FU_PC;
  logic        Output_FU_busy;
  logic        Output_FU_fault;

  int checks;
  int failures;
  int ir_pulses;

  instr_fetch_unit #(
    .PC_RESET(16'h0000),
    .PC_INC(16'd2),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .input_FU_start(input_FU_start),
    .input_FU_pc_load(input_FU_pc_load),
    .input_FU_pc_target(input_FU_pc_target),
    .input_FU_mem_data(input_FU_mem_data),
    .input_FU_mem_ready(input_FU_mem_ready),
    .Output_FU_mem_req(Output_FU_mem_req),
    .Output_FU_mem_addr(Output_FU_mem_addr),
    .Output_FU_Instru(Output_FU_Instru),
    .Output_FU_IR_write(Output_FU_IR_write),
    .Output_FU_PC(Output_FU_PC),
    .Output_FU_busy(Output_FU_busy),
    .Output_FU_fault(Output_FU_fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Counts cycles with IR_write high, sampled mid-cycle.
  always @(negedge CLK) if (Output_FU_IR_write === 1'b1) ir_pulses++;

  task automatic test_reset();
    RST_N = 1'b0;
    input_FU_start = 1'b0; input_FU_pc_load = 1'b0; input_FU_pc_target = '0;
    input_FU_mem_data = '0; input_FU_mem_ready = 1'b0;
    #3;
    checks++; if (Output_FU_mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", Output_FU_mem_req); end
    checks++; if (Output_FU_PC !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", Output_FU_PC); end
    checks++; if (Output_FU_mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", Output_FU_mem_addr); end
    checks++; if (Output_FU_Instru !== 16'h0000) begin failures++; $display("FAIL reset_instru got=%h exp=0000", Output_FU_Instru); end
    checks++; if (Output_FU_IR_write !== 1'b0) begin failures++; $display("FAIL reset_ir_write got=%b exp=0", Output_FU_IR_write); end
    checks++; if (Output_FU_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Output_FU_busy); end
    checks++; if (Output_FU_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", Output_FU_fault); end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  // Fetch with ready on the first FETCH cycle; ready also high in IDLE beforehand.
  task automatic test_basic_fetch();
    input_FU_start = 1'b1; input_FU_mem_data = 16'h1A2B; input_FU_mem_ready = 1'b1;
    @(negedge CLK);
    input_FU_start = 1'b0;
    checks++; if (Output_FU_mem_req !== 1'b1) begin failures++; $display("FAIL basic_req got=%b exp=1", Output_FU_mem_req); end
    checks++; if (Output_FU_mem_addr !== 16'h0000) begin failures++; $display("FAIL basic_addr got=%h exp=0000", Output_FU_mem_addr); end
    checks++; if (Output_FU_IR_write !== 1'b0) begin failures++; $display("FAIL basic_ir_early got=%b exp=0", Output_FU_IR_write); end
    @(negedge CLK);
    input_FU_mem_ready = 1'b0;
    checks++; if (Output_FU_IR_write !== 1'b1) begin failures++; $display("FAIL basic_ir_write got=%b exp=1", Output_FU_IR_write); end
    checks++; if (Output_FU_Instru !== 16'h1A2B) begin failures++; $display("FAIL basic_instru got=%h exp=1a2b", Output_FU_Instru); end
    checks++; if (Output_FU_PC !== 16'h0002) begin failures++; $display("FAIL basic_pc got=%h exp=0002", Output_FU_PC); end
    checks++; if (Output_FU_mem_req !== 1'b0) begin failures++; $display("FAIL basic_req_drop got=%b exp=0", Output_FU_mem_req); end
    @(negedge CLK);
    checks++; if (Output_FU_IR_write !== 1'b0 || Output_FU_busy !== 1'b0) begin failures++; $display("FAIL basic_idle ir=%b busy=%b exp=0,0", Output_FU_IR_write, Output_FU_busy); end
  endtask

  // Ready delayed by 3 cycles; then ready pulsed in IDLE must be ignored.
  task automatic test_wait_states();
    int req_cycles;
    int p0;
    req_cycles = 0;
    p0 = ir_pulses;
    input_FU_start = 1'b1; input_FU_mem_data = 16'h3C4D; input_FU_mem_ready = 1'b0;
    @(negedge CLK);
    input_FU_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (Output_FU_mem_req === 1'b1) req_cycles++;
      checks++; if (Output_FU_mem_addr !== 16'h0002 || Output_FU_IR_write !== 1'b0) begin failures++; $display("FAIL wait_addr_hold cyc=%0d addr=%h ir=%b exp=0002,0", i, Output_FU_mem_addr, Output_FU_IR_write); end
      if (i == 3) input_FU_mem_ready = 1'b1;
      @(negedge CLK);
    end
    input_FU_mem_ready = 1'b0;
    checks++; if (req_cycles != 4) begin failures++; $display("FAIL wait_req_cycles got=%0d exp=4", req_cycles); end
    checks++; if (Output_FU_IR_write !== 1'b1) begin failures++; $display("FAIL wait_ir_write got=%b exp=1", Output_FU_IR_write); end
    checks++; if (Output_FU_Instru !== 16'h3C4D || Output_FU_PC !== 16'h0004) begin failures++; $display("FAIL wait_result instru=%h pc=%h exp=3c4d,0004", Output_FU_Instru, Output_FU_PC); end
    @(negedge CLK);
    input_FU_mem_data = 16'hDEAD; input_FU_mem_ready = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    input_FU_mem_ready = 1'b0;
    checks++; if (ir_pulses - p0 != 1) begin failures++; $display("FAIL wait_single_pulse got=%0d exp=1", ir_pulses - p0); end
    checks++; if (Output_FU_Instru !== 16'h3C4D || Output_FU_busy !== 1'b0) begin failures++; $display("FAIL idle_ready_ignored instru=%h busy=%b exp=3c4d,0", Output_FU_Instru, Output_FU_busy); end
  endtask

  task automatic test_pc_load();
    input_FU_pc_load = 1'b1; input_FU_pc_target = 16'h00F0; input_FU_start = 1'b1;
    @(negedge CLK);
    input_FU_start = 1'b0; input_FU_pc_target = 16'h1234;   // load still high in FETCH
    checks++; if (Output_FU_mem_addr !== 16'h00F0 || Output_FU_mem_req !== 1'b1) begin failures++; $display("FAIL load_start_addr addr=%h req=%b exp=00f0,1", Output_FU_mem_addr, Output_FU_mem_req); end
    @(negedge CLK);
    input_FU_pc_load = 1'b0; input_FU_mem_data = 16'h5566; input_FU_mem_ready = 1'b1;
    checks++; if (Output_FU_PC !== 16'h00F0) begin failures++; $display("FAIL load_in_fetch pc=%h exp=00f0", Output_FU_PC); end
    @(negedge CLK);
    input_FU_mem_ready = 1'b0;
    checks++; if (Output_FU_PC !== 16'h00F2 || Output_FU_Instru !== 16'h5566) begin failures++; $display("FAIL load_fetch_result pc=%h instru=%h exp=00f2,5566", Output_FU_PC, Output_FU_Instru); end
    input_FU_pc_load = 1'b1; input_FU_pc_target = 16'h0100;  // load during WRITE
    @(negedge CLK);
    checks++; if (Output_FU_PC !== 16'h0100 || Output_FU_busy !== 1'b0) begin failures++; $display("FAIL load_in_write pc=%h busy=%b exp=0100,0", Output_FU_PC, Output_FU_busy); end
    input_FU_pc_target = 16'hFFFE;                          // plain load in IDLE
    @(negedge CLK);
    input_FU_pc_load = 1'b0;
    checks++; if (Output_FU_PC !== 16'hFFFE || Output_FU_busy !== 1'b0) begin failures++; $display("FAIL load_in_idle pc=%h busy=%b exp=fffe,0", Output_FU_PC, Output_FU_busy); end
  endtask

  // PC FFFE wraps to 0000; start held high throughout must give one fetch.
  task automatic test_wrap_back_to_back();
    int p0;
    p0 = ir_pulses;
    input_FU_start = 1'b1; input_FU_mem_data = 16'h7788; input_FU_mem_ready = 1'b0;
    @(negedge CLK);
    checks++; if (Output_FU_mem_addr !== 16'hFFFE) begin failures++; $display("FAIL wrap_addr got=%h exp=fffe", Output_FU_mem_addr); end
    @(negedge CLK);
    input_FU_mem_ready = 1'b1;
    @(negedge CLK);
    input_FU_mem_ready = 1'b0;
    checks++; if (Output_FU_PC !== 16'h0000 || Output_FU_Instru !== 16'h7788) begin failures++; $display("FAIL wrap_pc pc=%h instru=%h exp=0000,7788", Output_FU_PC, Output_FU_Instru); end
    @(negedge CLK);
    input_FU_start = 1'b0;
    checks++; if (Output_FU_busy !== 1'b0) begin failures++; $display("FAIL b2b_no_queue busy=%b exp=0", Output_FU_busy); end
    repeat (2) @(negedge CLK);
    checks++; if (ir_pulses - p0 != 1 || Output_FU_busy !== 1'b0) begin failures++; $display("FAIL b2b_one_fetch pulses=%0d busy=%b exp=1,0", ir_pulses - p0, Output_FU_busy); end
  endtask

  task automatic test_reset_mid_fetch();
    input_FU_pc_load = 1'b1; input_FU_pc_target = 16'h0200; input_FU_start = 1'b1;
    @(negedge CLK);
    input_FU_pc_load = 1'b0; input_FU_start = 1'b0;
    checks++; if (Output_FU_mem_req !== 1'b1 || Output_FU_mem_addr !== 16'h0200) begin failures++; $display("FAIL rst_pre_fetch req=%b addr=%h exp=1,0200", Output_FU_mem_req, Output_FU_mem_addr); end
    #2 RST_N = 1'b0;
    #1;
    checks++; if (Output_FU_mem_req !== 1'b0 || Output_FU_IR_write !== 1'b0) begin failures++; $display("FAIL rst_async_req req=%b ir=%b exp=0,0", Output_FU_mem_req, Output_FU_IR_write); end
    checks++; if (Output_FU_PC !== 16'h0000 || Output_FU_Instru !== 16'h0000) begin failures++; $display("FAIL rst_async_state pc=%h instru=%h exp=0000,0000", Output_FU_PC, Output_FU_Instru); end
    input_FU_mem_data = 16'hABCD; input_FU_mem_ready = 1'b1;
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    input_FU_mem_ready = 1'b0;
    checks++; if (Output_FU_busy !== 1'b0 || Output_FU_Instru !== 16'h0000 || Output_FU_IR_write !== 1'b0) begin failures++; $display("FAIL rst_late_ready busy=%b instru=%h ir=%b exp=0,0000,0", Output_FU_busy, Output_FU_Instru, Output_FU_IR_write); end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    int fetch_cycles;
    int p0;
    fetch_cycles = 0;
    p0 = ir_pulses;
    input_FU_start = 1'b1; input_FU_mem_ready = 1'b0;
    @(negedge CLK);
    input_FU_start = 1'b0;
    for (int i = 0; i < 40 && Output_FU_busy === 1'b1; i++) begin
      fetch_cycles++;
      @(negedge CLK);
    end
    checks++; if (fetch_cycles != 15) begin failures++; $display("FAIL timeout_cycles got=%0d exp=15", fetch_cycles); end
    checks++; if (Output_FU_fault !== 1'b1 || Output_FU_busy !== 1'b0) begin failures++; $display("FAIL timeout_fault fault=%b busy=%b exp=1,0", Output_FU_fault, Output_FU_busy); end
    checks++; if (Output_FU_PC !== 16'h0000 || Output_FU_Instru !== 16'h0000 || ir_pulses != p0) begin failures++; $display("FAIL timeout_state pc=%h instru=%h pulses=%0d exp=0000,0000,0", Output_FU_PC, Output_FU_Instru, ir_pulses - p0); end
    input_FU_start = 1'b1; input_FU_mem_data = 16'h0F0F; input_FU_mem_ready = 1'b1;
    @(negedge CLK);
    input_FU_start = 1'b0;
    checks++; if (Output_FU_fault !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%b exp=0", Output_FU_fault); end
    @(negedge CLK);
    input_FU_mem_ready = 1'b0;
    checks++; if (Output_FU_Instru !== 16'h0F0F || Output_FU_PC !== 16'h0002) begin failures++; $display("FAIL timeout_refetch instru=%h pc=%h exp=0f0f,0002", Output_FU_Instru, Output_FU_PC); end
    @(negedge CLK);
  endtask
`else
  task automatic test_no_timeout();
    int held;
    held = 0;
    input_FU_start = 1'b1; input_FU_mem_data = 16'h0F0F; input_FU_mem_ready = 1'b0;
    @(negedge CLK);
    input_FU_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (Output_FU_mem_req === 1'b1 && Output_FU_fault === 1'b0) held++;
      @(negedge CLK);
    end
    checks++; if (held != 20) begin failures++; $display("FAIL no_timeout_wait got=%0d exp=20", held); end
    input_FU_mem_ready = 1'b1;
    @(negedge CLK);
    input_FU_mem_ready = 1'b0;
    checks++; if (Output_FU_Instru !== 16'h0F0F || Output_FU_PC !== 16'h0002 || Output_FU_fault !== 1'b0) begin failures++; $display("FAIL no_timeout_done instru=%h pc=%h fault=%b exp=0f0f,0002,0", Output_FU_Instru, Output_FU_PC, Output_FU_fault); end
    @(negedge CLK);
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    ir_pulses = 0;
    test_reset();
    test_basic_fetch();
    test_wait_states();
    test_pc_load();
    test_wrap_back_to_back();
    test_reset_mid_fetch();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
